// File: rtl/fetch_unit_pkg.sv
// Pipeline-register types shared by the front end: IF/ID register and branch-predictor entry.
// Widths below are the build-wide defaults; fetch_unit and bht default their parameters to them.
package Pipe_Buf_Reg_PKG;

    localparam int PKG_PC_W      = 9;
    localparam int PKG_INS_W     = 32;
    localparam int PKG_BHT_DEPTH = 16;
    localparam int PKG_IDX_W     = $clog2(PKG_BHT_DEPTH);
    localparam int PKG_TAG_W     = PKG_PC_W - PKG_IDX_W - 2;

    typedef struct packed {
        logic                 valid;
        logic [PKG_TAG_W-1:0] tag;
        logic [PKG_PC_W-1:0]  target;
        logic [1:0]           ctr;
    } bht_entry_t;

    typedef struct packed {
        logic                 valid;
        logic [PKG_PC_W-1:0]  pc;
        logic [PKG_INS_W-1:0] instr;
        logic                 pred_taken;
        logic [PKG_PC_W-1:0]  pred_target;
    } if_id_t;

    // 2-bit saturating direction counter step
    function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken && ctr != 2'b11)
            res = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            res = ctr - 2'b01;
        return res;
    endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Direct-mapped, tagged branch target table with 2-bit counters.
// Lookup is combinational on pre-update contents; updates land on the clock edge.
module bht
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int PC_W      = PKG_PC_W,
    parameter int BHT_DEPTH = PKG_BHT_DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lookup_pc,
    output logic            lookup_hit,
    output logic            lookup_taken,
    output logic [PC_W-1:0] lookup_target,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [PC_W-1:0] upd_target
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    bht_entry_t entries_q [BHT_DEPTH];

    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             unused_lsbs;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[PC_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[PC_W-1:IDX_W+2];
    // instructions are word aligned, so the byte-offset bits carry no information
    assign unused_lsbs = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lookup_hit    = entries_q[l_idx].valid && (entries_q[l_idx].tag == l_tag);
    assign lookup_taken  = lookup_hit && entries_q[l_idx].ctr[1];
    assign lookup_target = entries_q[l_idx].target;

    assign u_hit = entries_q[u_idx].valid && (entries_q[u_idx].tag == u_tag);

    // Only valid bits are reset; tag/target/counter are don't-care while invalid.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BHT_DEPTH; i++)
                entries_q[i].valid <= 1'b0;
        end else if (upd_valid) begin
            if (u_hit) begin
                entries_q[u_idx].ctr <= ctr_update(entries_q[u_idx].ctr, upd_taken);
                if (upd_taken)
                    entries_q[u_idx].target <= upd_target;
            end else if (upd_taken) begin
                entries_q[u_idx] <= '{valid: 1'b1, tag: u_tag, target: upd_target, ctr: 2'b10};
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC selection with BHT prediction, IF/ID register.
// One-cycle fetch-to-IF/ID latency; redirect beats stall, stall freezes PC and IF/ID.
module fetch_unit
    import Pipe_Buf_Reg_PKG::*;
#(
    parameter int              PC_W      = PKG_PC_W,
    parameter int              INS_W     = PKG_INS_W,
    parameter int              BHT_DEPTH = PKG_BHT_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [INS_W-1:0] imem_rdata,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr,
    output logic             if_pred_taken,
    output logic [PC_W-1:0]  if_pred_target,
    output logic [15:0]      redirect_count
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] next_pc;
    if_id_t          if_q;
    logic [15:0]     redirect_count_q;

    logic            pred_hit;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            unused_hit;

    bht #(
        .PC_W      (PC_W),
        .BHT_DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk           (clk),
        .reset         (reset),
        .lookup_pc     (pc_q),
        .lookup_hit    (pred_hit),
        .lookup_taken  (pred_taken),
        .lookup_target (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target)
    );

    assign unused_hit = pred_hit;

    always_comb begin
        next_pc = pc_q + PC_W'(4);
        if (redirect_valid)
            next_pc = redirect_pc;
        else if (stall)
            next_pc = pc_q;
        else if (pred_taken)
            next_pc = pred_target;
    end

    always_ff @(posedge clk) begin
        if (reset)
            pc_q <= RESET_PC;
        else
            pc_q <= next_pc;
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) begin
            if_q <= '0;
        end else if (!stall) begin
            if_q <= '{valid:       1'b1,
                      pc:          pc_q,
                      instr:       imem_rdata,
                      pred_taken:  pred_taken,
                      pred_target: pred_taken ? pred_target : '0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            redirect_count_q <= '0;
        else if (redirect_valid && redirect_count_q != 16'hFFFF)
            redirect_count_q <= redirect_count_q + 16'd1;
    end

    assign imem_addr      = pc_q;
    assign if_valid       = if_q.valid;
    assign if_pc          = if_q.pc;
    assign if_instr       = if_q.instr;
    assign if_pred_taken  = if_q.pred_taken;
    assign if_pred_target = if_q.pred_target;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential PC flow, prediction training, stall/redirect, wrap and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;
    logic        upd_valid;
    logic [8:0]  upd_pc;
    logic        upd_taken;
    logic [8:0]  upd_target;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;
    logic        if_pred_taken;
    logic [8:0]  if_pred_target;
    logic [15:0] redirect_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return {8'hA5, 15'h0, a};
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    fetch_unit #(.PC_W(9), .INS_W(32), .BHT_DEPTH(16), .RESET_PC(9'h000)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_target     (upd_target),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pred_taken  (if_pred_taken),
        .if_pred_target (if_pred_target),
        .redirect_count (redirect_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic redirect_to(input logic [8:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        step();
        step();
        check("rst_addr",  32'(imem_addr), 32'h000);
        check("rst_valid", 32'(if_valid), 32'h0);
        check("rst_pc",    32'(if_pc), 32'h000);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pred",  32'(if_pred_taken), 32'h0);
        check("rst_count", 32'(redirect_count), 32'h0);

        // sequential fetch
        reset = 1'b0;
        step();
        check("seq1_addr",  32'(imem_addr), 32'h004);
        check("seq1_valid", 32'(if_valid), 32'h1);
        check("seq1_pc",    32'(if_pc), 32'h000);
        check("seq1_instr", if_instr, mem_word(9'h000));
        step();
        check("seq2_addr",  32'(imem_addr), 32'h008);
        check("seq2_pc",    32'(if_pc), 32'h004);

        // allocate taken entry at 0x010 -> 0x040
        upd_valid = 1'b1; upd_pc = 9'h010; upd_taken = 1'b1; upd_target = 9'h040;
        step();
        upd_valid = 1'b0;
        step();
        check("pre_hit_addr", 32'(imem_addr), 32'h010);
        step();
        check("hit_addr",   32'(imem_addr), 32'h040);
        check("hit_pc",     32'(if_pc), 32'h010);
        check("hit_taken",  32'(if_pred_taken), 32'h1);
        check("hit_target", 32'(if_pred_target), 32'h040);
        step();
        check("tgt_addr",   32'(imem_addr), 32'h044);
        check("tgt_pc",     32'(if_pc), 32'h040);
        check("tgt_taken",  32'(if_pred_taken), 32'h0);
        check("tgt_target", 32'(if_pred_target), 32'h000);

        // two more taken (saturate at 3), then one not-taken -> 2; updates while stalled
        stall = 1'b1;
        upd_valid = 1'b1; upd_taken = 1'b1;
        step();
        step();
        upd_taken = 1'b0;
        step();
        upd_valid = 1'b0;
        check("stall_addr", 32'(imem_addr), 32'h044);
        check("stall_pc",   32'(if_pc), 32'h040);
        stall = 1'b0;
        redirect_to(9'h010);
        check("rd1_addr",  32'(imem_addr), 32'h010);
        check("rd1_valid", 32'(if_valid), 32'h0);
        check("rd1_count", 32'(redirect_count), 32'h1);
        // second not-taken update in the same cycle as the lookup: lookup sees counter 2
        upd_valid = 1'b1; upd_pc = 9'h010; upd_taken = 1'b0;
        step();
        upd_valid = 1'b0;
        check("ctr2_addr",  32'(imem_addr), 32'h040);
        check("ctr2_taken", 32'(if_pred_taken), 32'h1);
        redirect_to(9'h010);
        step();
        check("ctr1_addr",   32'(imem_addr), 32'h014);
        check("ctr1_taken",  32'(if_pred_taken), 32'h0);
        check("ctr1_target", 32'(if_pred_target), 32'h000);

        // retrain to taken, then alias at 0x050 (same index, different tag)
        upd_valid = 1'b1; upd_pc = 9'h010; upd_taken = 1'b1; upd_target = 9'h040;
        step();
        upd_valid = 1'b0;
        redirect_to(9'h050);
        step();
        check("alias_addr",  32'(imem_addr), 32'h054);
        check("alias_taken", 32'(if_pred_taken), 32'h0);
        redirect_to(9'h010);
        step();
        check("retrain_addr", 32'(imem_addr), 32'h040);
        check("rd4_count",    32'(redirect_count), 32'h4);

        // redirect together with stall
        stall = 1'b1;
        redirect_to(9'h080);
        check("rs_addr",  32'(imem_addr), 32'h080);
        check("rs_valid", 32'(if_valid), 32'h0);
        check("rs_count", 32'(redirect_count), 32'h5);
        step();
        check("rs_hold_addr",  32'(imem_addr), 32'h080);
        check("rs_hold_valid", 32'(if_valid), 32'h0);
        stall = 1'b0;
        step();
        check("rs_go_addr",  32'(imem_addr), 32'h084);
        check("rs_go_pc",    32'(if_pc), 32'h080);
        check("rs_go_instr", if_instr, mem_word(9'h080));
        stall = 1'b1;
        step();
        check("hold_addr",  32'(imem_addr), 32'h084);
        check("hold_pc",    32'(if_pc), 32'h080);
        check("hold_valid", 32'(if_valid), 32'h1);
        stall = 1'b0;

        // PC wrap
        redirect_to(9'h1FC);
        step();
        check("wrap_addr",  32'(imem_addr), 32'h000);
        check("wrap_pc",    32'(if_pc), 32'h1FC);
        check("wrap_count", 32'(redirect_count), 32'h6);

        // reset while stalled, overriding redirect and update
        reset = 1'b1; stall = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 9'h080;
        upd_valid = 1'b1; upd_pc = 9'h020; upd_taken = 1'b1; upd_target = 9'h100;
        step();
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; upd_valid = 1'b0;
        check("rst2_addr",  32'(imem_addr), 32'h000);
        check("rst2_valid", 32'(if_valid), 32'h0);
        check("rst2_pc",    32'(if_pc), 32'h000);
        check("rst2_count", 32'(redirect_count), 32'h0);
        redirect_to(9'h010);
        step();
        check("rst2_miss10", 32'(imem_addr), 32'h014);
        redirect_to(9'h020);
        step();
        check("rst2_miss20", 32'(imem_addr), 32'h024);
        check("rst2_count2", 32'(redirect_count), 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, default 9: program-counter width in bits.
REQ-002 Parameter INS_W, default 32: instruction width in bits.
REQ-003 Parameter BHT_DEPTH, default 16: number of predictor entries; power of two, at least 2; IDX_W = log2(BHT_DEPTH); IDX_W+2 < PC_W.
REQ-004 Parameter RESET_PC, default 0: PC value loaded on reset.
REQ-005 Signal list (name / direction / width / meaning):
- clk / in / 1 / clock, rising edge.
- reset / in / 1 / synchronous, active-high.
- stall / in / 1 / hold PC and the IF/ID register.
- redirect_valid / in / 1 / EX-stage mispredict or flush.
- redirect_pc / in / PC_W / corrected fetch address.
- upd_valid / in / 1 / resolved control-transfer update.
- upd_pc / in / PC_W / PC of the resolved instruction.
- upd_taken / in / 1 / resolved direction.
- upd_target / in / PC_W / resolved target.
- imem_addr / out / PC_W / instruction-memory address, equal to the current PC.
- imem_rdata / in / INS_W / instruction word, combinational read of imem_addr.
- if_valid / out / 1 / IF/ID register holds a live instruction.
- if_pc / out / PC_W / PC of the IF/ID instruction.
- if_instr / out / INS_W / IF/ID instruction.
- if_pred_taken / out / 1 / prediction made for if_instr.
- if_pred_target / out / PC_W / predicted target (0 when not taken).
- redirect_count / out / 16 / saturating count of redirects.

Function
REQ-006 Next-PC priority, highest first:
- redirect_valid: load redirect_pc.
- stall: hold PC.
- predictor hit on PC with counter[1]=1: load the stored target.
- otherwise: PC+4, wrapping modulo 2^PC_W.
REQ-007 IF/ID register update:
- redirect_valid: clear if_valid, if_pc, if_instr, if_pred_taken and if_pred_target to 0.
- else stall: hold all IF/ID outputs.
- else: capture PC, imem_rdata and the prediction, and set if_valid=1.
REQ-008 Fetch-to-IF/ID latency is 1 cycle; a predicted-taken fetch incurs no bubble.
REQ-009 Predictor lookup: index = PC[IDX_W+1:2], tag = PC[PC_W-1:IDX_W+2]; an entry hits when valid=1 and its stored tag equals the tag.
REQ-010 Each entry holds: valid, tag, target (PC_W bits) and a 2-bit saturating counter.
REQ-011 Update on upd_valid, by case:
- Hit, taken: counter = min(counter+1, 3); target = upd_target.
- Hit, not taken: counter = max(counter-1, 0); target unchanged.
- Miss, taken: allocate or overwrite the entry with valid=1, the new tag, upd_target, counter=2'b10.
- Miss, not taken: no change.
REQ-012 An update and a lookup in the same cycle (same or different index) use the pre-update contents; the update is visible from the next cycle.
REQ-013 The predictor updates regardless of stall and of redirect_valid.
REQ-014 redirect_count increments by 1 on each cycle with redirect_valid=1 and saturates at 16'hFFFF.
REQ-015 redirect_valid and stall asserted together: redirect wins for both the PC and the IF/ID register.

Reset
REQ-016 On reset:
- PC = RESET_PC.
- if_valid = 0; if_pc, if_instr, if_pred_taken, if_pred_target and redirect_count = 0.
- All predictor valid bits = 0, in a single cycle.
REQ-017 Reset overrides redirect_valid, stall and upd_valid in the same cycle; asserting reset mid-stream discards all in-flight state.
REQ-018 imem_addr = RESET_PC in the cycle after reset is sampled.

Structure
REQ-019 The entry typedef bht_entry_t and the IF/ID output struct shall live in Pipe_Buf_Reg_PKG, alongside the existing pipeline-register types.
REQ-020 The predictor table shall be one sub-module, bht, with lookup port (pc -> hit, taken, target) and update port; fetch_unit holds the PC, next-PC mux, IF/ID register and counter.

Verification (PC_W=9, BHT_DEPTH=16, RESET_PC=0)
REQ-021 Reset released, no updates -> imem_addr 0x000, 0x004, 0x008 on successive cycles; if_valid=0 in the first cycle after reset, then 1 with if_pc 0x000.
REQ-022 upd_valid, upd_pc=0x010, upd_taken=1, upd_target=0x040, then fetch reaches 0x010 -> next imem_addr=0x040, if_pred_taken=1, if_pred_target=0x040.
REQ-023 Three taken updates at 0x010, then one not-taken update -> still predicts taken (counter 2); a second not-taken update -> predicts not taken and next PC = 0x014.
REQ-024 Entry allocated at 0x010, fetch at 0x050 (same index, different tag) -> no hit, next PC = 0x054.
REQ-025 stall=1 and redirect_valid=1 with redirect_pc=0x080 -> next imem_addr=0x080, if_valid=0, redirect_count increments by 1.
REQ-026 PC=0x1FC with no hit -> next PC = 0x000; reset asserted while stalled -> PC=0x000 and all entries miss on the next cycle.
